// File: rtl/layer_stream_arbiter_if.sv
// rtl/layer_stream_arbiter_if.sv - handshake bundle shared by the arbiter, both requesters, the layer and both consumers
interface layer_stream_arbiter_if #(
   parameter int T = 16
);
   // requester 0 / 1 input streams
   logic         s0_valid;
   logic [T-1:0] s0_data;
   logic         s0_ready;
   logic         s1_valid;
   logic [T-1:0] s1_data;
   logic         s1_ready;

   // layer input port
   logic         l_valid;
   logic [T-1:0] l_data;
   logic         l_ready;

   // layer result port
   logic         lo_valid;
   logic [T-1:0] lo_data;
   logic         lo_ready;

   // consumer 0 / 1 result streams
   logic         m0_valid;
   logic [T-1:0] m0_data;
   logic         m0_ready;
   logic         m1_valid;
   logic [T-1:0] m1_data;
   logic         m1_ready;

   // arbiter side
   modport master (
      input  s0_valid, s0_data, s1_valid, s1_data,
      output s0_ready, s1_ready,
      output l_valid, l_data,
      input  l_ready,
      input  lo_valid, lo_data,
      output lo_ready,
      output m0_valid, m0_data, m1_valid, m1_data,
      input  m0_ready, m1_ready
   );

   // environment side: producers, layer and consumers
   modport slave (
      output s0_valid, s0_data, s1_valid, s1_data,
      input  s0_ready, s1_ready,
      input  l_valid, l_data,
      output l_ready,
      output lo_valid, lo_data,
      input  lo_ready,
      input  m0_valid, m0_data, m1_valid, m1_data,
      output m0_ready, m1_ready
   );
endinterface

// File: rtl/layer_stream_arbiter.sv
// rtl/layer_stream_arbiter.sv - two-requester round-robin scheduler time-sharing one fully-connected layer
module layer_stream_arbiter #(
   parameter int N = 10,
   parameter int M = 8,
   parameter int T = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   layer_stream_arbiter_if.master bus,
   output logic                   grant,
   output logic                   busy
);

   localparam int INW  = (N > 1) ? $clog2(N) : 1;
   localparam int OUTW = (M > 1) ? $clog2(M) : 1;
   localparam logic [INW-1:0]  IN_LAST  = INW'(N - 1);
   localparam logic [OUTW-1:0] OUT_LAST = OUTW'(M - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FEED  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   logic [1:0]      state_q, state_d;
   logic            grant_q, grant_d;
   logic            last_grant_q, last_grant_d;
   logic [INW-1:0]  in_cnt_q, in_cnt_d;
   logic [OUTW-1:0] out_cnt_q, out_cnt_d;

   logic in_beat;
   logic out_beat;

   assign grant = grant_q;
   assign busy  = (state_q != ST_IDLE);

   // Route the granted requester to the layer in FEED and the layer back to its consumer in DRAIN;
   // every other handshake output is forced low and every unrouted data output to zero.
   always_comb begin
      bus.s0_ready = 1'b0;
      bus.s1_ready = 1'b0;
      bus.l_valid  = 1'b0;
      bus.l_data   = '0;
      bus.lo_ready = 1'b0;
      bus.m0_valid = 1'b0;
      bus.m0_data  = '0;
      bus.m1_valid = 1'b0;
      bus.m1_data  = '0;
      case (state_q)
         ST_FEED: begin
            if (grant_q) begin
               bus.l_valid  = bus.s1_valid;
               bus.l_data   = bus.s1_data;
               bus.s1_ready = bus.l_ready;
            end else begin
               bus.l_valid  = bus.s0_valid;
               bus.l_data   = bus.s0_data;
               bus.s0_ready = bus.l_ready;
            end
         end
         ST_DRAIN: begin
            if (grant_q) begin
               bus.m1_valid = bus.lo_valid;
               bus.m1_data  = bus.lo_data;
               bus.lo_ready = bus.m1_ready;
            end else begin
               bus.m0_valid = bus.lo_valid;
               bus.m0_data  = bus.lo_data;
               bus.lo_ready = bus.m0_ready;
            end
         end
         default: begin
         end
      endcase
   end

   // Beats are qualified by state so a stray partner handshake in the wrong phase never counts.
   always_comb begin
      in_beat  = (state_q == ST_FEED)  && bus.l_valid  && bus.l_ready;
      out_beat = (state_q == ST_DRAIN) && bus.lo_valid && bus.lo_ready;
   end

   // Next-state: arbitrate in IDLE, count N input beats in FEED, count M result beats in DRAIN.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      in_cnt_d     = in_cnt_q;
      out_cnt_d    = out_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.s0_valid || bus.s1_valid) begin
               // a tie goes to whoever was not served last; otherwise the lone requester wins
               if (bus.s0_valid && bus.s1_valid) begin
                  grant_d = ~last_grant_q;
               end else begin
                  grant_d = bus.s1_valid;
               end
               state_d   = ST_FEED;
               in_cnt_d  = '0;
               out_cnt_d = '0;
            end
         end
         ST_FEED: begin
            if (in_beat) begin
               in_cnt_d = in_cnt_q + 1'b1;
               if (in_cnt_q == IN_LAST) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (out_beat) begin
               out_cnt_d = out_cnt_q + 1'b1;
               if (out_cnt_q == OUT_LAST) begin
                  // the final result only returns to IDLE; arbitration waits for the next cycle
                  state_d      = ST_IDLE;
                  last_grant_d = grant_q;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers; last_grant resets to 1 so requester 0 wins the first tie.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
         in_cnt_q     <= '0;
         out_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         in_cnt_q     <= in_cnt_d;
         out_cnt_q    <= out_cnt_d;
      end
   end

endmodule

// File: tb/tb_layer_stream_arbiter.sv
// tb/tb_layer_stream_arbiter.sv - self-checking bench for layer_stream_arbiter
module tb_layer_stream_arbiter;
   localparam int N = 10;
   localparam int M = 8;
   localparam int T = 16;

   logic clk = 1'b0;
   logic reset;
   logic grant;
   logic busy;

   layer_stream_arbiter_if #(.T(T)) bus ();

   layer_stream_arbiter #(.N(N), .M(M), .T(T)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .grant (grant),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // requester model
   int         vecs[2];
   int         k[2];
   int         txn[2];
   int         gap_at[2];
   int         gap_len[2];
   int         gap_cnt[2];
   int         mcnt[2];
   logic [T-1:0] sum[2];
   // scoreboard: expected result words per consumer
   logic [T-1:0] q0[$];
   logic [T-1:0] q1[$];
   // layer model
   int         lay_cnt;
   int         lay_left;
   int         lay_idx;
   logic [T-1:0] lay_sum;
   logic [T-1:0] lay_base;
   int         owner;
   // pattern knobs and observers
   bit         lr_tog;
   bit         mr_tog[2];
   int         cyc;
   bit         busy_p;
   int         idle_run;
   bit         chk_gap;
   int         gseq[$];

   typedef struct {
      bit v0;
      bit v1;
      bit exp_g;
   } arb_vec_t;
   arb_vec_t tbl[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 2; i++) begin
         vecs[i] = 0; k[i] = 0; txn[i] = 0; gap_at[i] = -1; gap_len[i] = 0;
         gap_cnt[i] = 0; mcnt[i] = 0; sum[i] = '0; mr_tog[i] = 1'b0;
      end
      q0.delete();
      q1.delete();
      gseq.delete();
      lay_cnt = 0; lay_left = 0; lay_idx = 0; lay_sum = '0; lay_base = '0;
      owner = 0; lr_tog = 1'b0; busy_p = 1'b0; idle_run = 0; chk_gap = 1'b0;
   endtask

   task automatic drive();
      logic [T-1:0] d[2];
      bit v[2];
      cyc++;
      for (int i = 0; i < 2; i++) begin
         v[i] = (vecs[i] > 0);
         if (v[i] && k[i] == gap_at[i] && gap_cnt[i] < gap_len[i]) begin
            v[i] = 1'b0;
            gap_cnt[i]++;
         end
         d[i] = T'((i << 12) | ((txn[i] & 255) << 4) | k[i]);
      end
      bus.s0_valid = v[0];
      bus.s0_data  = d[0];
      bus.s1_valid = v[1];
      bus.s1_data  = d[1];
      bus.l_ready  = (lay_left == 0) && (!lr_tog || cyc[0]);
      bus.lo_valid = (lay_left > 0);
      bus.lo_data  = (lay_left > 0) ? lay_base + T'(lay_idx) : '0;
      bus.m0_ready = !mr_tog[0] || cyc[0];
      bus.m1_ready = !mr_tog[1] || cyc[0];
   endtask

   task automatic sample();
      bit hs[2];
      logic [T-1:0] sd[2];
      logic [T-1:0] exp_w;
      bit lb, lob, mb0, mb1, g;
      hs[0] = bus.s0_valid && bus.s0_ready;
      hs[1] = bus.s1_valid && bus.s1_ready;
      sd[0] = bus.s0_data;
      sd[1] = bus.s1_data;
      lb  = bus.l_valid && bus.l_ready;
      lob = bus.lo_valid && bus.lo_ready;
      mb0 = bus.m0_valid && bus.m0_ready;
      mb1 = bus.m1_valid && bus.m1_ready;
      g   = grant;

      if (!busy) begin
         chk("idle_outputs", 32'({bus.s0_ready, bus.s1_ready, bus.l_valid, bus.lo_ready,
             bus.m0_valid, bus.m1_valid, (bus.m0_data != '0), (bus.m1_data != '0)}), 32'(0));
      end else if (!g) begin
         chk("nongranted_quiet", 32'({bus.s1_ready, bus.m1_valid, (bus.m1_data != '0)}), 32'(0));
      end else begin
         chk("nongranted_quiet", 32'({bus.s0_ready, bus.m0_valid, (bus.m0_data != '0)}), 32'(0));
      end
      if (busy && lay_left > 0) begin
         chk("drain_lo_ready", 32'(bus.lo_ready), 32'(owner ? bus.m1_ready : bus.m0_ready));
         chk("drain_l_valid", 32'(bus.l_valid), 32'(0));
      end
      if (busy && lay_left == 0) begin
         chk("feed_l_valid", 32'(bus.l_valid), 32'(g ? bus.s1_valid : bus.s0_valid));
         chk("feed_lo_ready", 32'(bus.lo_ready), 32'(0));
      end
      if (lb || hs[0] || hs[1]) begin
         chk("l_beat_align", 32'(lb), 32'(hs[0] || hs[1]));
         chk("l_data", 32'(bus.l_data), 32'(hs[1] ? sd[1] : sd[0]));
      end
      if (lob || mb0 || mb1) begin
         chk("m_beat_align", 32'(lob), 32'(mb0 || mb1));
      end

      if (busy && !busy_p) begin
         gseq.push_back(int'(g));
         if (chk_gap) chk("idle_gap", 32'(idle_run), 32'(1));
         idle_run = 0;
      end
      if (!busy) idle_run++;
      busy_p = busy;

      for (int i = 0; i < 2; i++) begin
         if (hs[i]) begin
            sum[i] = sum[i] + sd[i];
            k[i]++;
            if (k[i] == N) begin
               for (int j = 0; j < M; j++) begin
                  if (i == 0) q0.push_back(sum[i] + T'(j));
                  else        q1.push_back(sum[i] + T'(j));
               end
               owner = i;
               vecs[i]--;
               k[i] = 0;
               sum[i] = '0;
               txn[i]++;
               gap_cnt[i] = 0;
            end
         end
      end
      if (lb) begin
         lay_sum = lay_sum + bus.l_data;
         lay_cnt++;
         if (lay_cnt == N) begin
            lay_left = M; lay_idx = 0; lay_base = lay_sum; lay_cnt = 0; lay_sum = '0;
         end
      end
      if (lob) begin
         lay_idx++;
         lay_left--;
      end
      if (mb0) begin
         if (q0.size() == 0) chk("m0_unexpected", 32'(1), 32'(0));
         else begin
            exp_w = q0.pop_front();
            chk("m0_data", 32'(bus.m0_data), 32'(exp_w));
         end
         mcnt[0]++;
      end
      if (mb1) begin
         if (q1.size() == 0) chk("m1_unexpected", 32'(1), 32'(0));
         else begin
            exp_w = q1.pop_front();
            chk("m1_data", 32'(bus.m1_data), 32'(exp_w));
         end
         mcnt[1]++;
      end
   endtask

   task automatic step();
      @(negedge clk);
      sample();
      @(posedge clk);
      #1;
      drive();
   endtask

   task automatic run_done(input string name, input int budget);
      int n;
      bit pending;
      n = 0;
      pending = 1'b1;
      while (pending && n < budget) begin
         step();
         n++;
         pending = (vecs[0] > 0) || (vecs[1] > 0) || busy_p || (lay_left > 0);
      end
      chk({name, "_timeout"}, 32'(pending), 32'(0));
   endtask

   task automatic wait_busy(output int n);
      n = 0;
      while (!busy_p && n < 40) begin
         step();
         n++;
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      model_clear();
      drive();
      repeat (2) step();
      reset = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1);
   end

   initial begin
      int n;
      int e;
      tbl[0] = '{1'b1, 1'b0, 1'b0};
      tbl[1] = '{1'b0, 1'b1, 1'b1};
      tbl[2] = '{1'b1, 1'b1, 1'b0};
      tbl[3] = '{1'b1, 1'b1, 1'b1};
      tbl[4] = '{1'b1, 1'b1, 1'b0};
      tbl[5] = '{1'b0, 1'b1, 1'b1};
      tbl[6] = '{1'b1, 1'b1, 1'b0};
      cyc = 0;

      // reset values
      reset = 1'b0;
      model_clear();
      drive();
      #1;
      chk("reset_grant", 32'(grant), 32'(0));
      chk("reset_busy", 32'(busy), 32'(0));
      chk("reset_outputs", 32'({bus.s0_ready, bus.s1_ready, bus.l_valid, bus.lo_ready,
          bus.m0_valid, bus.m1_valid}), 32'(0));
      chk("reset_data", 32'({bus.l_data, bus.m0_data}) | 32'(bus.m1_data), 32'(0));
      repeat (2) step();
      reset = 1'b1;

      // arbitration table: one vector per entry, loser withdraws once the winner is granted
      for (int i = 0; i < 7; i++) begin
         e = int'(tbl[i].exp_g);
         vecs[0] = int'(tbl[i].v0);
         vecs[1] = int'(tbl[i].v1);
         mcnt[0] = 0;
         mcnt[1] = 0;
         drive();
         wait_busy(n);
         chk("arb_latency", 32'(n), 32'(2));
         chk("arb_grant", 32'(grant), 32'(tbl[i].exp_g));
         vecs[1 - e] = 0;
         run_done("vector", 200);
         chk("owner_words", 32'(mcnt[e]), 32'(M));
         chk("other_words", 32'(mcnt[1 - e]), 32'(0));
         chk("queues_empty", 32'(q0.size() + q1.size()), 32'(0));
         step();
         chk("idle_grant_hold", 32'(grant), 32'(tbl[i].exp_g));
         chk("idle_busy", 32'(busy), 32'(0));
      end

      // round robin: both continuously valid for 4 vectors
      do_reset();
      chk_gap = 1'b1;
      vecs[0] = 2;
      vecs[1] = 2;
      idle_run = 0;
      drive();
      run_done("round_robin", 600);
      chk("rr_count", 32'(gseq.size()), 32'(4));
      for (int i = 0; i < 4 && i < gseq.size(); i++) begin
         chk("rr_grant", 32'(gseq[i]), 32'(i % 2));
      end
      chk("rr_m0_words", 32'(mcnt[0]), 32'(16));
      chk("rr_m1_words", 32'(mcnt[1]), 32'(16));

      // backpressure: m0_ready and l_ready toggle every cycle
      do_reset();
      mr_tog[0] = 1'b1;
      lr_tog = 1'b1;
      vecs[0] = 1;
      drive();
      run_done("backpressure", 400);
      chk("bp_words", 32'(mcnt[0]), 32'(M));
      chk("bp_queue", 32'(q0.size()), 32'(0));

      // input gap: s1_valid low for 3 cycles after beat 5
      do_reset();
      gap_at[1] = 5;
      gap_len[1] = 3;
      vecs[1] = 1;
      drive();
      n = 0;
      while (k[1] != 5 && n < 40) begin
         step();
         n++;
      end
      chk("gap_reach", 32'(k[1]), 32'(5));
      for (int i = 0; i < 3; i++) begin
         step();
         chk("gap_busy", 32'(busy), 32'(1));
         chk("gap_still_feed", 32'({bus.l_valid, bus.lo_ready, bus.s0_ready, bus.m1_valid}), 32'(0));
      end
      run_done("gap", 200);
      chk("gap_words", 32'(mcnt[1]), 32'(M));

      // reset mid-FEED after 4 beats of requester 1
      do_reset();
      vecs[1] = 1;
      drive();
      n = 0;
      while (k[1] != 4 && n < 40) begin
         step();
         n++;
      end
      chk("mid_grant_before", 32'(grant), 32'(1));
      reset = 1'b0;
      #1;
      chk("mid_reset_outputs", 32'({bus.s0_ready, bus.s1_ready, bus.l_valid, bus.lo_ready,
          bus.m0_valid, bus.m1_valid}), 32'(0));
      chk("mid_reset_grant", 32'(grant), 32'(0));
      chk("mid_reset_busy", 32'(busy), 32'(0));
      model_clear();
      drive();
      repeat (2) step();
      reset = 1'b1;
      vecs[1] = 1;
      drive();
      wait_busy(n);
      chk("post_reset_grant", 32'(grant), 32'(1));
      run_done("post_reset", 200);
      chk("post_reset_words", 32'(mcnt[1]), 32'(M));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
